muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >=8).
REQ-002 SHALL have parameter DIVZERO_FLAG, default 1, enabling the divzero output (0 ties it low).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-007 a, b  input  WIDTH each  rs and rt operands, captured on the start edge.
REQ-008 flush  input  1  abort the in-flight operation; pipeline squash.
REQ-009 hl_read  input  1  decode stage is issuing MFHI/MFLO.
REQ-010 mthi, mtlo  input  1 each  direct HI or LO write request.
REQ-011 wdata  input  WIDTH  data for mthi/mtlo.
REQ-012 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-015 stall  output  1  = busy & (start | hl_read | mthi | mtlo).
REQ-016 divzero  output  1  pulses with done when a DIV/DIVU had b == 0.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FIX.
REQ-018 IDLE->RUN SHALL occur on start; a, b and op are latched and the iteration counter is cleared.
REQ-019 RUN SHALL perform one radix-2 step per cycle on operand magnitudes.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
REQ-020 RUN->FIX SHALL occur after exactly WIDTH steps.
REQ-021 FIX SHALL apply sign correction, write HI/LO, pulse done and return to IDLE.
REQ-022 Latency: start sampled at edge E0 -> busy=1 in cycles after E0..E(WIDTH+1) -> new hi/lo and done=1 in the cycle after edge E(WIDTH+1); back-to-back starts SHALL be accepted the cycle done is high.
REQ-023 Multiply results SHALL be the full 2*WIDTH-bit product, HI = upper half, LO = lower half.
  - MULT: signed two's complement.
  - MULTU: unsigned.
REQ-024 Divide results SHALL be LO = quotient, HI = remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
REQ-025 Divide by zero SHALL give LO = all ones and HI = a, with divzero=1 for that done cycle.
REQ-026 DIV of most-negative by -1 SHALL give LO = most-negative and HI = 0.
REQ-027 flush while busy SHALL return to IDLE on the next edge, with no done and HI/LO unchanged.
REQ-028 flush in IDLE SHALL have no effect; flush together with start in IDLE SHALL suppress the start.
REQ-029 start, mthi and mtlo while busy SHALL be ignored; upstream holds them under stall.
REQ-030 mthi/mtlo in IDLE SHALL write hi/lo on the next edge; if start is also present the write occurs and start is still accepted.
REQ-031 hl_read SHALL never modify state; hi/lo always reflect the last committed value.
REQ-032 No HI/LO change SHALL occur in RUN.

Reset
REQ-033 While reset=0 the unit SHALL enter IDLE immediately: hi=0, lo=0, busy=0, done=0, divzero=0, counter=0.
REQ-034 Reset mid-operation SHALL discard the operation, with no done after release.
REQ-035 The first start SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-036 Shared package muldiv_pkg SHALL hold the op enum (MULT, MULTU, DIV, DIVU), the FSM state enum and the default WIDTH constant; the main decoder imports the same enum.
REQ-037 One combinational sub-module, muldiv_signfix, SHALL perform magnitude extraction and result negation.
REQ-038 The counter SHALL be $clog2(WIDTH)+1 bits; no multiplier or divider primitives are permitted.

Verification (WIDTH=32)
REQ-039 MULT a=0xFFFFFFFD(-3), b=5 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle.
REQ-040 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-041 DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, divzero=1 with done.
REQ-042 MULTU 0xFFFFFFFF*0xFFFFFFFF, flush at cycle 10 -> busy drops next edge, no done, hi/lo keep prior values.
REQ-043 hl_read and mthi during RUN -> stall=1 every such cycle, hi unchanged; mthi wdata=0xA5 in IDLE -> hi=0xA5 next cycle.
REQ-044 reset=0 asserted mid-DIV -> outputs zero asynchronously; start after release -> correct result after 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction and final result sign correction (combinational).
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg_quot,
  output logic               neg_rem,
  input  logic               is_div,
  input  logic               fix_neg_quot,
  input  logic               fix_neg_rem,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic sign_a;
  logic sign_b;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg;
  logic [WIDTH-1:0]   rem_neg;

  // Absolute values of the operands and the signs the result must take.
  always_comb begin
    sign_a   = is_signed & a[WIDTH-1];
    sign_b   = is_signed & b[WIDTH-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
    neg_quot = sign_a ^ sign_b;
    neg_rem  = sign_a;
  end

  // Product negates as one 2*WIDTH value; quotient and remainder negate independently.
  always_comb begin
    prod_neg = -raw;
    quot_neg = -raw[WIDTH-1:0];
    rem_neg  = -raw[2*WIDTH-1:WIDTH];
    res_hi   = raw[2*WIDTH-1:WIDTH];
    res_lo   = raw[WIDTH-1:0];
    if (is_div) begin
      if (fix_neg_quot) res_lo = quot_neg;
      if (fix_neg_rem)  res_hi = rem_neg;
    end else if (fix_neg_quot) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH        = MULDIV_WIDTH,
  parameter bit          DIVZERO_FLAG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hl_read,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             divzero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dz_out_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_quot;
  logic               neg_rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step_next;

  assign accept = start & ~flush;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a            (a),
    .b            (b),
    .is_signed    (op_is_signed(op_e'(op))),
    .mag_a        (mag_a),
    .mag_b        (mag_b),
    .neg_quot     (neg_quot),
    .neg_rem      (neg_rem),
    .is_div       (op_is_div(op_q)),
    .fix_neg_quot (neg_quot_q),
    .fix_neg_rem  (neg_rem_q),
    .raw          (acc_q),
    .res_hi       (fix_hi),
    .res_lo       (fix_lo)
  );

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // Divide keeps {remainder, dividend/quotient} in acc; the borrow bit of the
  // trial subtraction decides the quotient bit since remainder < divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (op_is_div(op_q)) begin
      if (!div_diff[WIDTH]) step_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  step_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (flush)                           state_d = IDLE;
        else if (cnt_q == CW'(WIDTH - 1))    state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, HI/LO commit and done/divzero pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      op_q       <= MULT;
      a_q        <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_out_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (accept) begin
            op_q       <= op_e'(op);
            a_q        <= a;
            mag_b_q    <= mag_b;
            acc_q      <= {{WIDTH{1'b0}}, mag_a};
            cnt_q      <= '0;
            neg_quot_q <= neg_quot;
            neg_rem_q  <= neg_rem;
            dz_q       <= op_is_div(op_e'(op)) && (b == '0);
          end
        end
        RUN: begin
          if (!flush) begin
            acc_q <= step_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            if (dz_q) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= fix_hi;
              lo_q <= fix_lo;
            end
            done_q   <= 1'b1;
            dz_out_q <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign stall   = busy & (start | hl_read | mthi | mtlo);
  assign divzero = DIVZERO_FLAG ? dz_out_q : 1'b0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, hand sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         hl_read = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;
  logic         divzero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
  } vec_t;

  vec_t vt[14];

  muldiv_unit #(.WIDTH(W), .DIVZERO_FLAG(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .hl_read (hl_read),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .divzero (divzero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, C-style truncating division.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
    longint      sx, sy, sp;
    logic [63:0] up;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    mdz = 1'b0;
    mh  = '0;
    ml  = '0;
    case (o)
      2'd0: begin sp = sx * sy; mh = sp[63:32]; ml = sp[31:0]; end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; mh = up[63:32]; ml = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          mh = x; ml = '1; mdz = 1'b1;
        end else if (o == 2'd2) begin
          sp = sx / sy; ml = sp[31:0];
          sp = sx % sy; mh = sp[31:0];
        end else begin
          ml = x / y; mh = x % y;
        end
      end
    endcase
  endfunction

  // Waits up to a bounded number of edges for done; checks latency, result and HI/LO stability meanwhile.
  task automatic wait_result(input string tag, input int lat_exp, input logic [31:0] eh,
                             input logic [31:0] el, input logic edz);
    logic [31:0] h0, l0;
    int lat;
    bit held;
    h0 = hi; l0 = lo; lat = 0; held = 1'b1;
    for (int k = 1; k <= lat_exp + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " divzero"}, divzero, edz);
    chk({tag, " hilo_held_in_run"}, held, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1'b1);
    wait_result(tag, W + 1, eh, el, edz);
  endtask

  initial begin
    logic [31:0] mh, ml, rx, ry;
    logic        mdz;
    logic [1:0]  ro;
    bit          quiet;

    vt[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[1]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    vt[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[6]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vt[7]  = '{DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vt[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vt[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[10] = '{DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
    vt[11] = '{MULTU, 32'd0,        32'h00012345, 32'd0,        32'd0,        1'b0};
    vt[12] = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vt[13] = '{MULT,  32'd5,        32'd0,        32'd0,        32'd0,        1'b0};

    // Reset state, then start accepted on the first edge after release.
    #12;
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset divzero", divzero, 1'b0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_start busy", busy, 1'b1);
    wait_result("first_start", W + 1, 32'd0, 32'd42, 1'b0);

    // Directed vector table, issued back to back.
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vt[i].o, vt[i].x, vt[i].y, vt[i].eh, vt[i].el, vt[i].edz);

    // Direct HI/LO writes in IDLE.
    @(negedge clk); mthi = 1'b1; wdata = 32'h000000A5;
    @(posedge clk); #1; mthi = 1'b0;
    chk("mthi idle", hi, 32'h000000A5);
    @(negedge clk); mtlo = 1'b1; wdata = 32'h0000005A;
    @(posedge clk); #1; mtlo = 1'b0;
    chk("mtlo idle", lo, 32'h0000005A);

    // Stall during RUN; mthi and start while busy are ignored.
    @(negedge clk); op = DIVU; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; hl_read = 1'b1; #1;
    chk("stall hl_read", stall, 1'b1);
    mthi = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = MULT; a = 32'd3; b = 32'd3; #1;
    chk("stall mthi", stall, 1'b1);
    @(posedge clk); #1;
    chk("busy mthi ignored", hi, 32'h000000A5);
    mthi = 1'b0; start = 1'b0; hl_read = 1'b0; #1;
    chk("stall quiet", stall, 1'b0);
    wait_result("stall_div", W + 1 - 4, 32'd0, 32'd100, 1'b0);
    hl_read = 1'b1; #1;
    chk("stall idle", stall, 1'b0);
    hl_read = 1'b0;

    // Restore known HI/LO, then flush a MULTU at cycle 10.
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h000000A5;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk); op = MULTU; a = '1; b = '1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush busy", busy, 1'b0);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || hi !== 32'h000000A5 || lo !== 32'h000000A5) quiet = 1'b0;
    end
    chk("flush no_done_hilo_kept", quiet, 1'b1);

    // Flush together with start in IDLE suppresses the start.
    @(negedge clk); op = MULT; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush_start busy", busy, 1'b0);

    // mtlo and start in the same IDLE cycle: both take effect.
    @(negedge clk); mtlo = 1'b1; wdata = 32'h77; start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; mtlo = 1'b0; start = 1'b0;
    chk("mtlo_start lo", lo, 32'h77);
    chk("mtlo_start busy", busy, 1'b1);
    wait_result("mtlo_start", W + 1, 32'd0, 32'd12, 1'b0);

    // Reset in the middle of a DIV clears everything asynchronously.
    @(negedge clk); mthi = 1'b1; wdata = 32'hBEEF;
    @(posedge clk); #1; mthi = 1'b0;
    @(negedge clk); op = DIV; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk("async_reset hi", hi, '0);
    chk("async_reset lo", lo, '0);
    chk("async_reset busy", busy, 1'b0);
    chk("async_reset done", done, 1'b0);
    @(negedge clk); reset = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    chk("after_reset no_done", quiet, 1'b1);
    run_op("post_reset_div", DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = '1;
        2: rx = 32'h80000000;
        3: ry = 32'($urandom_range(1, 15));
        default: ;
      endcase
      model(ro, rx, ry, mh, ml, mdz);
      run_op($sformatf("rand%0d op=%0d a=%h b=%h", i, ro, rx, ry), ro, rx, ry, mh, ml, mdz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
